// File: rtl/mult_recon_pkg.sv
// Shared types for the shift-add dividend reconstructor.
package mult_recon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mult_cell.sv
// One Horner step of the reconstruction: shift the accumulator and add the divisor on a set quotient bit.
module mult_cell #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 3
) (
    input  logic [N+M-1:0] acc_i,
    input  logic           qbit,
    input  logic [M-1:0]   divisor,
    output logic [N+M-1:0] acc_o
);

    localparam int unsigned P = N + M;

    always_comb begin
        acc_o = {acc_i[P-2:0], 1'b0} + (qbit ? P'(divisor) : P'(0));
    end

endmodule

// File: rtl/multiplier_recon.sv
// Sequential reconstructor: product = merchant*divisor + remainder, one quotient bit per cycle.
module multiplier_recon
    import mult_recon_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned M = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             data_rdy,
    input  logic [N-1:0]     merchant,
    input  logic [M-1:0]     divisor,
    input  logic [M-1:0]     remainder,
    output logic             in_ready,
    output logic             res_rdy,
    output logic [N+M-1:0]   product,
    output logic             rem_err
);

    localparam int unsigned P  = N + M;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nxt;
    logic [N-1:0]   q_reg, q_reg_nxt;
    logic [M-1:0]   d_reg, d_reg_nxt;
    logic [M-1:0]   r_reg, r_reg_nxt;
    logic [P-1:0]   acc, acc_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           err_reg, err_reg_nxt;
    logic           in_ready_nxt;
    logic           res_rdy_nxt;
    logic [P-1:0]   product_nxt;
    logic           rem_err_nxt;
    logic [P-1:0]   acc_step;

    mult_cell #(
        .N (N),
        .M (M)
    ) u_cell (
        .acc_i   (acc),
        .qbit    (q_reg[cnt]),
        .divisor (d_reg),
        .acc_o   (acc_step)
    );

    // Next-state and next-register values
    always_comb begin
        state_nxt   = state;
        q_reg_nxt   = q_reg;
        d_reg_nxt   = d_reg;
        r_reg_nxt   = r_reg;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        err_reg_nxt = err_reg;
        res_rdy_nxt = 1'b0;
        product_nxt = product;
        rem_err_nxt = rem_err;

        case (state)
            IDLE: begin
                if (data_rdy) begin
                    q_reg_nxt   = merchant;
                    d_reg_nxt   = divisor;
                    r_reg_nxt   = remainder;
                    acc_nxt     = '0;
                    cnt_nxt     = CW'(N - 1);
                    err_reg_nxt = (remainder >= divisor);
                    state_nxt   = CALC;
                end
            end
            CALC: begin
                acc_nxt = acc_step;
                if (cnt == '0) begin
                    state_nxt = FINISH;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            FINISH: begin
                product_nxt = acc + P'(r_reg);
                rem_err_nxt = err_reg;
                res_rdy_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt == IDLE);
    end

    // State and register update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            q_reg    <= '0;
            d_reg    <= '0;
            r_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            err_reg  <= 1'b0;
            in_ready <= 1'b1;
            res_rdy  <= 1'b0;
            product  <= '0;
            rem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            q_reg    <= q_reg_nxt;
            d_reg    <= d_reg_nxt;
            r_reg    <= r_reg_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            err_reg  <= err_reg_nxt;
            in_ready <= in_ready_nxt;
            res_rdy  <= res_rdy_nxt;
            product  <= product_nxt;
            rem_err  <= rem_err_nxt;
        end
    end

endmodule

// File: tb/tb_multiplier_recon.sv
// Directed bench for multiplier_recon with immediate-assertion checks (N=5, M=3).
module tb_multiplier_recon;

    localparam int unsigned N = 5;
    localparam int unsigned M = 3;
    localparam int unsigned P = N + M;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         data_rdy = 1'b0;
    logic [N-1:0] merchant = '0;
    logic [M-1:0] divisor = '0;
    logic [M-1:0] remainder = '0;
    logic         in_ready;
    logic         res_rdy;
    logic [P-1:0] product;
    logic         rem_err;

    int compared = 0;
    int mismatched = 0;

    multiplier_recon #(
        .N (N),
        .M (M)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_rdy  (data_rdy),
        .merchant  (merchant),
        .divisor   (divisor),
        .remainder (remainder),
        .in_ready  (in_ready),
        .res_rdy   (res_rdy),
        .product   (product),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (res_rdy !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (in_ready !== 1'b1 && c < 30) begin
            tick();
            c++;
        end
    endtask

    // Accept one operation, scramble the inputs, then check latency, result and pulse width
    task automatic run_op(input string tag, input int q, input int d, input int r,
                          input int exp_p, input int exp_e);
        int cyc;
        wait_idle();
        merchant  = N'(q);
        divisor   = M'(d);
        remainder = M'(r);
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        merchant  = N'($urandom);
        divisor   = M'($urandom);
        remainder = M'($urandom);
        check({tag, "_busy"}, 32'(in_ready), 0);
        wait_res(cyc);
        check({tag, "_latency"}, 32'(cyc), 6);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        check({tag, "_rem_err"}, 32'(rem_err), 32'(exp_e));
        tick();
        check({tag, "_pulse"}, 32'(res_rdy), 0);
        check({tag, "_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int cyc;
        int pulses;
        int q, d, r;

        // Reset held with data_rdy asserted: the input must be dropped
        rstn      = 1'b0;
        data_rdy  = 1'b1;
        merchant  = 5'd9;
        divisor   = 3'd3;
        remainder = 3'd1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_res_rdy", 32'(res_rdy), 0);
        check("rst_product", 32'(product), 0);
        check("rst_rem_err", 32'(rem_err), 0);
        data_rdy = 1'b0;
        rstn = 1'b1;
        tick();
        check("rst_drop_in_ready", 32'(in_ready), 1);

        run_op("basic", 5, 5, 4, 29, 0);
        run_op("max_legal", 31, 7, 6, 223, 0);
        run_op("zero_q", 0, 3, 2, 2, 0);
        run_op("bad_rem", 2, 3, 5, 11, 1);
        run_op("div_zero", 0, 0, 1, 1, 1);
        run_op("all_ones_err", 31, 7, 7, 224, 1);

        // Busy: second request two cycles after accept is ignored
        wait_idle();
        merchant  = 5'd3;
        divisor   = 3'd2;
        remainder = 3'd1;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        tick();
        merchant  = 5'd7;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        wait_res(cyc);
        check("busy_latency", 32'(cyc + 2), 6);
        check("busy_product", 32'(product), 7);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_rdy === 1'b1) pulses++;
        end
        check("busy_single_res", 32'(pulses), 0);

        // Back-to-back accepts with data_rdy held high
        merchant  = 5'd1;
        divisor   = 3'd1;
        remainder = 3'd0;
        data_rdy  = 1'b1;
        wait_res(cyc);
        check("b2b_first_product", 32'(product), 1);
        tick();
        check("b2b_pulse", 32'(res_rdy), 0);
        cyc = 1;
        while (res_rdy !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        data_rdy = 1'b0;
        check("b2b_spacing", 32'(cyc), 7);
        wait_idle();

        // Reset during the third CALC cycle aborts the operation
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        merchant  = 5'd31;
        divisor   = 3'd7;
        remainder = 3'd6;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_res_rdy", 32'(res_rdy), 0);
        check("midrst_product", 32'(product), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_rdy === 1'b1) pulses++;
        end
        check("midrst_no_res", 32'(pulses), 0);
        check("midrst_product_held", 32'(product), 0);
        run_op("after_rst", 6, 5, 3, 33, 0);

        // Random legal operands against q*d+r
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(1, 7));
            r = int'($urandom_range(0, d - 1));
            q = int'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), q, d, r, q * d + r, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
